// File: rtl/status_cond_pkg.sv
// Shared constants and sizing helpers for the status conditioner.
// Chatter detection is built only when STATUS_COND_CHATTER_EN is defined.
package status_cond_pkg;

    localparam int DEF_N_CH        = 32'sd4;
    localparam int DEF_CTR_WIDTH   = 32'sd4;
    localparam int DEF_HIGH_THRESH = 32'sd12;
    localparam int DEF_LOW_THRESH  = 32'sd3;
    localparam int DEF_WIN_LEN     = 32'sd256;
    localparam int DEF_CHATTER_MAX = 32'sd4;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2_f(input int value);
        int result;
        result = 32'sd1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 32'sd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    function automatic int settle_f(input int ctr_width);
        return 32'sd2 + (32'sd1 << ctr_width);
    endfunction

endpackage

// File: rtl/status_cond_chan.sv
// One conditioned channel: synchronizer, hysteresis counter, edge pulses and,
// with STATUS_COND_CHATTER_EN defined, the transition count and sticky chatter flag.
module status_cond_chan
    import status_cond_pkg::*;
#(
    parameter int   CTR_WIDTH   = DEF_CTR_WIDTH,
    parameter int   HIGH_THRESH = DEF_HIGH_THRESH,
    parameter int   LOW_THRESH  = DEF_LOW_THRESH,
    parameter logic RST_BIT     = 1'b0,
    parameter int   CHATTER_MAX = DEF_CHATTER_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic win_wrap,
    input  logic chatter_clr,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic chatter
);

    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] CTR_ZERO = {CTR_WIDTH{1'b0}};
    localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1'b1);
    localparam logic [CTR_WIDTH-1:0] CTR_HI   = CTR_WIDTH'(HIGH_THRESH);
    localparam logic [CTR_WIDTH-1:0] CTR_LO   = CTR_WIDTH'(LOW_THRESH);
    localparam logic [CTR_WIDTH-1:0] CTR_RST  = RST_BIT ? CTR_MAX : CTR_ZERO;

    logic                 sync1_r, sync2_r, clean_r, rise_r, fall_r;
    logic [CTR_WIDTH-1:0] ctr_r, ctr_next_s;
    logic                 clean_next_s, rise_next_s, fall_next_s;

    // Saturating counter step and hysteresis decision on the next-state count.
    always_comb begin
        ctr_next_s = ctr_r;
        if (sync2_r) begin
            if (ctr_r != CTR_MAX) ctr_next_s = ctr_r + CTR_ONE;
            else                  ctr_next_s = ctr_r;
        end else begin
            if (ctr_r != CTR_ZERO) ctr_next_s = ctr_r - CTR_ONE;
            else                   ctr_next_s = ctr_r;
        end
        if (ctr_next_s >= CTR_HI)      clean_next_s = 1'b1;
        else if (ctr_next_s <= CTR_LO) clean_next_s = 1'b0;
        else                           clean_next_s = clean_r;
        rise_next_s = clean_next_s & ~clean_r;
        fall_next_s = ~clean_next_s & clean_r;
    end

    // Synchronizer, counter and registered level/edge outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= RST_BIT;
            sync2_r <= RST_BIT;
            ctr_r   <= CTR_RST;
            clean_r <= RST_BIT;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            ctr_r   <= ctr_next_s;
            clean_r <= clean_next_s;
            rise_r  <= rise_next_s;
            fall_r  <= fall_next_s;
        end
    end

    assign clean = clean_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

`ifdef STATUS_COND_CHATTER_EN
    localparam int             CNT_W    = clog2_f(CHATTER_MAX + 32'sd1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHATTER_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic             chatter_r, chatter_next_s, event_s, reach_s;

    // Windowed transition count; a flag set beats a same-cycle clear.
    always_comb begin
        event_s        = rise_next_s | fall_next_s;
        cnt_next_s     = cnt_r;
        chatter_next_s = chatter_r;
        reach_s        = 1'b0;
        if (win_wrap) begin
            cnt_next_s = event_s ? CNT_ONE : CNT_ZERO;
            reach_s    = event_s && (CNT_ONE == CNT_MAX);
        end else if (event_s && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_ONE;
            reach_s    = (cnt_r == (CNT_MAX - CNT_ONE));
        end else begin
            cnt_next_s = cnt_r;
        end
        if (reach_s) begin
            chatter_next_s = 1'b1;
        end else if (chatter_clr) begin
            chatter_next_s = 1'b0;
            cnt_next_s     = CNT_ZERO;
        end else begin
            chatter_next_s = chatter_r;
        end
    end

    // Transition count and sticky chatter flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= CNT_ZERO;
            chatter_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_next_s;
            chatter_r <= chatter_next_s;
        end
    end

    assign chatter = chatter_r;
`else
    localparam int chatter_max_unused = CHATTER_MAX;
    logic chatter_in_unused;
    assign chatter_in_unused = win_wrap ^ chatter_clr;
    assign chatter           = 1'b0;
`endif

endmodule

// File: rtl/status_conditioner.sv
// Multi-channel status conditioner top: per-channel conditioners, shared
// chatter window (STATUS_COND_CHATTER_EN) and post-reset settle indication.
module status_conditioner
    import status_cond_pkg::*;
#(
    parameter int              N_CH        = DEF_N_CH,
    parameter int              CTR_WIDTH   = DEF_CTR_WIDTH,
    parameter int              HIGH_THRESH = DEF_HIGH_THRESH,
    parameter int              LOW_THRESH  = DEF_LOW_THRESH,
    parameter logic [N_CH-1:0] RST_VAL     = {N_CH{1'b0}},
    parameter int              WIN_LEN     = DEF_WIN_LEN,
    parameter int              CHATTER_MAX = DEF_CHATTER_MAX
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] async_i,
    output logic [N_CH-1:0] clean_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] chatter_o,
    input  logic [N_CH-1:0] chatter_clr_i,
    output logic            valid_o
);

    localparam int               SETTLE      = settle_f(CTR_WIDTH);
    localparam int               SET_W       = clog2_f(SETTLE + 32'sd1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 32'sd1);
    localparam logic [SET_W-1:0] SET_ONE     = SET_W'(1'b1);

    logic [SET_W-1:0] settle_r;
    logic             valid_r;
    logic             win_wrap_s;

    // Settle counter stops once valid is raised; valid is sticky until reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            settle_r <= {SET_W{1'b0}};
            valid_r  <= 1'b0;
        end else if (!valid_r) begin
            settle_r <= settle_r + SET_ONE;
            valid_r  <= (settle_r == SETTLE_LAST);
        end else begin
            settle_r <= settle_r;
            valid_r  <= valid_r;
        end
    end

    assign valid_o = valid_r;

`ifdef STATUS_COND_CHATTER_EN
    localparam int               WIN_W    = clog2_f(WIN_LEN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 32'sd1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1'b1);

    logic [WIN_W-1:0] win_r;

    assign win_wrap_s = (win_r == WIN_LAST);

    // Free-running chatter observation window shared by all channels.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)           win_r <= {WIN_W{1'b0}};
        else if (win_wrap_s) win_r <= {WIN_W{1'b0}};
        else                 win_r <= win_r + WIN_ONE;
    end
`else
    localparam int win_len_unused = WIN_LEN;
    assign win_wrap_s = 1'b0;
`endif

    for (genvar n = 0; n < N_CH; n++) begin : g_chan
        status_cond_chan #(
            .CTR_WIDTH   (CTR_WIDTH),
            .HIGH_THRESH (HIGH_THRESH),
            .LOW_THRESH  (LOW_THRESH),
            .RST_BIT     (RST_VAL[n]),
            .CHATTER_MAX (CHATTER_MAX)
        ) u_chan (
            .clk         (clk_i),
            .rst         (rst_i),
            .raw         (async_i[n]),
            .win_wrap    (win_wrap_s),
            .chatter_clr (chatter_clr_i[n]),
            .clean       (clean_o[n]),
            .rise        (rise_o[n]),
            .fall        (fall_o[n]),
            .chatter     (chatter_o[n])
        );
    end

endmodule

// File: tb/tb_status_conditioner.sv
// Directed self-checking bench for status_conditioner (RST_VAL = 4'b0101);
// chatter expectations follow STATUS_COND_CHATTER_EN.
module tb_status_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] async_in;
    logic [3:0] clr;
    logic [3:0] clean, rise, fall, chatter;
    logic       valid;

    int checks   = 0;
    int failures = 0;
    int ecnt     = 0;

    logic [3:0] exp_clean, exp_rise, exp_fall, exp_chat;
    logic       c1, r1, f1, h1;

    status_conditioner #(
        .RST_VAL (4'b0101)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .async_i       (async_in),
        .clean_o       (clean),
        .rise_o        (rise),
        .fall_o        (fall),
        .chatter_o     (chatter),
        .chatter_clr_i (clr),
        .valid_o       (valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, ecnt, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        async_in = 4'b0000;
        clr      = 4'b0000;

        // Scenario 1: reset values, falling channels 0/2, valid at edge 18
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clean", 32'(clean), 32'h5);
        chk("rst_rise", 32'(rise), 32'h0);
        chk("rst_fall", 32'(fall), 32'h0);
        chk("rst_chatter", 32'(chatter), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        rst  = 1'b0;
        ecnt = 0;
        for (int i = 0; i < 18; i++) begin
            step();
            chk("s1_valid", 32'(valid), (ecnt >= 18) ? 32'h1 : 32'h0);
            chk("s1_clean", 32'(clean), (ecnt >= 14) ? 32'h0 : 32'h5);
            chk("s1_fall", 32'(fall), (ecnt == 14) ? 32'h5 : 32'h0);
        end

        // Scenario 2: channel 0 rises 14 edges after the first sampling edge
        step();
        step();
        async_in[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("s2_clean", 32'(clean), (ecnt >= 34) ? 32'h1 : 32'h0);
            chk("s2_rise", 32'(rise), (ecnt == 34) ? 32'h1 : 32'h0);
        end

        // Scenario 3: 5-cycle glitch and 10-cycle pulse on channel 3 are rejected
        while (ecnt < 90) begin
            if (ecnt == 36 || ecnt == 60) async_in[3] = 1'b1;
            if (ecnt == 41 || ecnt == 70) async_in[3] = 1'b0;
            step();
            chk("s3_clean", 32'(clean), 32'h1);
            chk("s3_rise", 32'(rise), 32'h0);
        end

        // Scenario 4: channel 1 toggles every 20 cycles from the wrap at edge 256
        while (ecnt < 256) step();
        for (int k = 0; k < 165; k++) begin
            if (((ecnt - 256) % 20 == 0) && (ecnt <= 396)) async_in[1] = ~async_in[1];
            clr[1] = (ecnt == 335 || ecnt == 409);
            step();
            c1 = (ecnt >= 270 && ecnt < 290) || (ecnt >= 310 && ecnt < 330) ||
                 (ecnt >= 350 && ecnt < 370) || (ecnt >= 390 && ecnt < 410);
            r1 = (ecnt == 270 || ecnt == 310 || ecnt == 350 || ecnt == 390);
            f1 = (ecnt == 290 || ecnt == 330 || ecnt == 370 || ecnt == 410);
`ifdef STATUS_COND_CHATTER_EN
            h1 = (ecnt >= 330 && ecnt < 336) || (ecnt >= 410);
`else
            h1 = 1'b0;
`endif
            exp_clean = {2'b00, c1, 1'b1};
            exp_rise  = {2'b00, r1, 1'b0};
            exp_fall  = {2'b00, f1, 1'b0};
            exp_chat  = {2'b00, h1, 1'b0};
            chk("s4_clean", 32'(clean), 32'(exp_clean));
            chk("s4_rise", 32'(rise), 32'(exp_rise));
            chk("s4_fall", 32'(fall), 32'(exp_fall));
            chk("s4_chatter", 32'(chatter), 32'(exp_chat));
        end
        clr = 4'b0000;

        // Scenario 5: multi-channel rise, then asynchronous reset mid-pulse
        async_in = 4'b1111;
        for (int i = 0; i < 14; i++) begin
            step();
            chk("s5_clean", 32'(clean), (ecnt >= 435) ? 32'hF : 32'h1);
            chk("s5_rise", 32'(rise), (ecnt == 435) ? 32'hE : 32'h0);
        end
        #3;
        rst = 1'b1;
        #1;
        chk("arst_clean", 32'(clean), 32'h5);
        chk("arst_rise", 32'(rise), 32'h0);
        chk("arst_fall", 32'(fall), 32'h0);
        chk("arst_chatter", 32'(chatter), 32'h0);
        chk("arst_valid", 32'(valid), 32'h0);
        step();
        rst  = 1'b0;
        ecnt = 0;
        for (int i = 0; i < 18; i++) begin
            step();
            chk("s5b_valid", 32'(valid), (ecnt >= 18) ? 32'h1 : 32'h0);
            chk("s5b_clean", 32'(clean), (ecnt >= 14) ? 32'hF : 32'h5);
            chk("s5b_rise", 32'(rise), (ecnt == 14) ? 32'hA : 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/status_conditioner.md
# status_conditioner

Multi-channel conditioner for asynchronous analog status signals such as comparator, saturation and reference-ready lines. It is the parametrised successor to the four-line fixed sanitizer. Each of `N_CH` lines gets:
- a two-flop synchronizer and a saturating up/down hysteresis counter;
- registered rise/fall event pulses and a per-channel sticky chatter (instability) fault.

A global `valid_o` tells downstream control logic when the conditioned outputs have settled after reset. The block sits between the analog front-end pins and the measurement sequencer.

## Interface
- `N_CH`, default 4: number of channels, range 1..32.
- `CTR_WIDTH`, default 4: width of the hysteresis counter; the counter saturates at 2^CTR_WIDTH-1.
- `HIGH_THRESH`, default 12: counter value at or above which the channel output is 1. Requires LOW_THRESH < HIGH_THRESH ≤ 2^CTR_WIDTH-1.
- `LOW_THRESH`, default 3: counter value at or below which the channel output is 0.
- `RST_VAL`, default {N_CH{1'b0}}: per-channel reset value of the synchronizer flops and `clean_o`.
- `WIN_LEN`, default 256: chatter observation window, in cycles; must be ≥ 2.
- `CHATTER_MAX`, default 4: number of transitions within one window that sets the channel's chatter fault; must be ≥ 1.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `async_i` in N_CH: raw asynchronous status inputs.
- `clean_o` out N_CH: filtered, synchronous status outputs.
- `rise_o` out N_CH: one-cycle pulse when `clean_o[n]` goes 0→1.
- `fall_o` out N_CH: one-cycle pulse when `clean_o[n]` goes 1→0.
- `chatter_o` out N_CH: sticky chatter fault per channel.
- `chatter_clr_i` in N_CH: write-1-to-clear for `chatter_o` and the channel's transition count.
- `valid_o` out 1: outputs have settled since the last reset.

## Operation
- **Reset (asynchronous, immediate, including mid-operation):**
  - Sync flops and `clean_o[n]` are set to `RST_VAL[n]`.
  - Counter[n] is set to 0 if `RST_VAL[n]`=0, otherwise to 2^CTR_WIDTH-1.
  - `rise_o`, `fall_o`, `chatter_o`, `valid_o`, the transition counts, the window counter and the settle counter are all set to 0.
- **Synchronizer:** `async_i[n]` passes through two flops to give `sync[n]`.
- **Hysteresis counter:**
  - Each cycle, counter[n] increments if `sync[n]`=1 and decrements if `sync[n]`=0.
  - It saturates at 0 and at 2^CTR_WIDTH-1 and never wraps.
- **Output decision:** `clean_o[n]` is registered from the next-state counter value:
  - 1 if counter_next ≥ HIGH_THRESH;
  - 0 if counter_next ≤ LOW_THRESH;
  - otherwise it holds its previous value.
- **Edge events:**
  - `rise_o[n]` / `fall_o[n]` are registered alongside `clean_o`.
  - Each is high for exactly the first cycle in which `clean_o[n]` shows its new value.
  - They are never both high on the same channel.
- **Chatter detection** (only when `STATUS_COND_CHATTER_EN` is defined):
  - A free-running window counter runs from 0 to WIN_LEN-1 and wraps to 0.
  - Per channel, a transition count increments on each rise or fall event and saturates at CHATTER_MAX.
  - On the edge where the window counter wraps, the count loads 1 if an event occurs on that same edge, otherwise 0.
  - `chatter_o[n]` sets on the edge where the count reaches CHATTER_MAX and stays set until cleared.
  - `chatter_clr_i[n]` clears both the count and `chatter_o[n]`. If a set and a clear occur on the same edge, the set wins.
  - Chatter detection never affects `clean_o`.
- **Settle indication:**
  - A settle counter counts edges after `rst_i` deasserts.
  - `valid_o` sets on edge SETTLE = 2 + 2^CTR_WIDTH (18 at default parameters) and is sticky until the next reset.

## Timing
- **Latency, rising:** an input stable at 1 is first captured at edge 1 with the counter at 0. `clean_o` rises at edge 2+HIGH_THRESH, which is edge 14 at default parameters.
- **Latency, falling:** from a saturated counter, `clean_o` falls at edge 2+(2^CTR_WIDTH-1-LOW_THRESH), which is edge 14 at default parameters.
- **Glitch rejection:** any input pulse shorter than HIGH_THRESH-LOW_THRESH cycles, applied from a settled state, produces no output change.
- **Stuck inputs:** there is no handshake. Every output is a registered level or pulse, and a stuck input simply yields a stable `clean_o`.

## Configuration
- **`STATUS_COND_CHATTER_EN` defined:** the window counter, transition counts and `chatter_o` logic are built as described.
- **`STATUS_COND_CHATTER_EN` undefined:**
  - `chatter_o` is tied to 0 and `chatter_clr_i` is ignored.
  - No window or transition-count registers exist; `WIN_LEN` and `CHATTER_MAX` are unused.

## Structure
- **Shared package `status_cond_pkg`:**
  - default parameter constants;
  - a clog2 helper for sizing the window counter and transition counts;
  - the SETTLE formula.
- **Sub-module `status_cond_chan`:** one instance per channel in a generate loop, containing the synchronizer, hysteresis counter, `clean_o` register, edge pulses and (if enabled) the transition count and chatter flag.
- **Top level:** the shared window counter and the settle counter.

## Test plan
1. Hold `rst_i`=1 with `RST_VAL`=4'b0101 → `clean_o`=0101; `rise_o`, `fall_o`, `chatter_o` and `valid_o` all 0. Release reset → `valid_o`=1 exactly at edge 18.
2. After settling, step `async_i[0]` 0→1 → `clean_o[0]`=1 at edge 14 after the first sampling edge, and `rise_o[0]` is a single-cycle pulse in that same cycle.
3. On a settled-low channel, apply a 5-cycle high glitch, then a 10-cycle high pulse → `clean_o` stays 0 and `rise_o` never asserts for either.
4. Toggle `async_i[1]` every 20 cycles, starting just after a window wrap → four events inside 256 cycles, so `chatter_o[1]` sets on the 4th event. Pulse `chatter_clr_i[1]` → the flag clears. A clear coinciding with a new 4th event leaves the flag set.
5. Assert `rst_i` asynchronously mid-toggle → all outputs go to their reset values before the next clock edge, and `valid_o` drops.
6. Build without `STATUS_COND_CHATTER_EN`, repeat scenario 4 → `chatter_o` stays 0 while `clean_o`, `rise_o` and `fall_o` behave exactly as in the enabled build.
